uart_tx_buffered: RTL and testbench
===================================

// Module: uart_tx_buffered
// PURPOSE
//  Buffered 8N1 UART transmitter behind the IO block's UART_TX MMIO register.
//  Accepts bytes from the MMIO write path into a small FIFO and serialises them,
//  LSB first, on the uart_tx pin.
//  Drives the busy bit that software polls at UART status offset 0x8, bit0.
// PARAMETERS
//  CLKS_PER_BIT  868  clock cycles per serial bit (100 MHz / 115200); must be >= 2
//  FIFO_DEPTH    4    byte entries; power of two, >= 2
// PORTS
//  clk       in   1                       system clock, single clock domain
//  rst       in   1                       synchronous, active-high reset
//  wr_valid  in   1                       MMIO store to UART_TX accepted by decode
//  wr_data   in   8                       byte to send (mmio_wdata[7:0])
//  wr_ready  out  1                       FIFO can take a byte this cycle (= !full)
//  busy      out  1                       FIFO non-empty OR frame in flight
//  full      out  1                       FIFO holds FIFO_DEPTH bytes
//  level     out  $clog2(FIFO_DEPTH+1)    bytes currently queued (excludes shifter)
//  uart_tx   out  1                       serial line, idle high
// BEHAVIOUR
//  - Reset values: uart_tx=1, busy=0, full=0, level=0, wr_ready=1.
//    FIFO pointers cleared; FSM returns to IDLE; baud counter and bit index set to 0.
//  - Reset mid-frame aborts the frame: uart_tx is high from the edge where rst is sampled.
//  - Push occurs when wr_valid && wr_ready. wr_valid while full is dropped, with no side effect.
//    There is no bypass path.
//  - Pop occurs only in IDLE when level != 0: the head byte loads into the shifter and the FSM enters START.
//  - Same-cycle push and pop: both take effect and level is unchanged.
//  - Push at level = FIFO_DEPTH-1 sets full on the next cycle.
//  - Latency: a byte pushed at edge N (FSM idle, FIFO empty) is popped at edge N+1.
//    uart_tx goes low (start bit) from edge N+1.
//  - busy is registered.
//    It goes high on the edge after the first accepted push.
//    It goes low on the edge that completes the last stop bit while the FIFO is empty.
//    It never drops between back-to-back frames.
//  - FSM states:
//    IDLE  -> START when FIFO is not empty.
//    START -> DATA after CLKS_PER_BIT cycles; uart_tx=0 during START.
//    DATA  -> STOP after 8 bits; uart_tx = shifter[0]; the shifter moves right each bit period.
//    STOP  -> IDLE after CLKS_PER_BIT cycles; uart_tx=1.
//    Back-to-back bytes pass through IDLE for exactly one cycle with the line held high.
//  - Frame length = 10*CLKS_PER_BIT cycles, plus 1 idle cycle between queued frames.
//  - Baud counter counts 0..CLKS_PER_BIT-1 and reloads to 0 at each bit boundary.
//    Width is $clog2(CLKS_PER_BIT).
//  - Bit index is 3 bits and wraps 7->0 on the DATA->STOP transition.
//  - FIFO pointers are log2(DEPTH)+1 bits wide.
//    full/empty are derived from the MSB difference, so wrap-around needs no special case.
// STRUCTURE
//  - defines.vh gains `IO_UART_CLKS_PER_BIT and `IO_UART_FIFO_DEPTH as defaults.
//    The IO block passes these down.
//  - FSM state encodings are localparams in this file.
//  - One sub-module, sync_fifo (parameters WIDTH and DEPTH; push/pop/full/empty/level ports).
//    It is reusable for a later UART RX path.
//  - The IO block keeps address decode. mmio_ready for UART_TX = wr_ready.
//  - Status read bit0 = busy. bit1 = full.
// TESTING (bench CLKS_PER_BIT=4, FIFO_DEPTH=4)
//  1. Reset: hold rst for 3 cycles mid-frame.
//     -> Next edge: uart_tx=1, busy=0, level=0. No further line transitions.
//  2. Single byte 0xA5 pushed at edge N.
//     -> uart_tx low on [N+1, N+5).
//     -> Bits 1,0,1,0,0,1,0,1, each 4 cycles.
//     -> High stop bit through N+41. busy falls at N+41.
//  3. Burst: 0x00,0x11,0x22,0x33,0x44 on consecutive cycles.
//     -> First pop overlaps the second push. level peaks at 3, then 4, and full=1.
//     -> wr_ready=0 drops no accepted byte.
//     -> Decoded line stream is 0x00..0x44 in order, with 41-cycle frame spacing.
//  4. Overflow: wr_valid held with 0xFF while full.
//     -> No extra frame is sent. level stays <= 4.
//  5. Simultaneous push/pop at level=2.
//     -> level stays 2 that cycle. Byte order is preserved.
//  6. Wrap: 16 bytes, idx*0x11, written with busy polling as software does.
//     -> Serial decoder sees 0x00..0xFF. busy=0 only after the final stop bit.

Source files
------------

// File: rtl/uart_tx_buffered_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered_pkg
//   Shared definitions for the buffered 8N1 UART transmitter: default build
//   parameters for the IO block, frame constants, the transmit FSM state type
//   and a helper that maps an FSM state to the serial line level.
// -----------------------------------------------------------------------------
package uart_tx_buffered_pkg;

    // Defaults the IO block passes down: 100 MHz / 115200 baud, 4-byte queue.
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
    localparam int unsigned DEFAULT_FIFO_DEPTH   = 4;

    // 8N1 framing: one start bit, eight data bits, one stop bit.
    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Serial line level for a given state. In DATA the line carries the
    // current LSB of the shifter; every other state except START is high.
    function automatic logic line_level(input tx_state_e st, input logic data_bit);
        logic lvl;
        case (st)
            ST_START: lvl = 1'b0;
            ST_DATA:  lvl = data_bit;
            default:  lvl = 1'b1;
        endcase
        return lvl;
    endfunction

endpackage : uart_tx_buffered_pkg

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with registered pointers. Written to be reused by a
//   later UART RX path, so it carries no UART-specific knowledge.
//
//   Ports
//     clk        in   1            system clock
//     rst        in   1            synchronous, active-high reset (pointers only)
//     push       in   1            write request; ignored while full
//     push_data  in   WIDTH        data written on an accepted push
//     pop        in   1            read request; ignored while empty
//     pop_data   out  WIDTH        head entry (valid while !empty)
//     full       out  1            DEPTH entries held
//     empty      out  1            no entries held
//     level      out  clog2(D+1)   number of entries held
//
//   Pointers are one bit wider than the address. Equal pointers mean empty;
//   equal address bits with differing MSBs mean full, so wrap-around needs
//   no special case. DEPTH must be a power of two, >= 2.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic [WIDTH-1:0]                 push_data,
    input  logic                             pop,
    output logic [WIDTH-1:0]                 pop_data,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(DEPTH+1)-1:0]       level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level   = LW'(wr_ptr_q - rd_ptr_q);

    // A push while full and a pop while empty are silently dropped.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which
    // entries are valid, and leaving the array out of reset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule : sync_fifo

// File: rtl/uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered
//   Buffered 8N1 UART transmitter sitting behind the UART_TX MMIO register.
//   Bytes from the MMIO write path are queued in a small FIFO and sent LSB
//   first on uart_tx. busy feeds status bit0, full feeds status bit1, and
//   wr_ready is the MMIO ready for stores to UART_TX.
//
//   Parameters
//     CLKS_PER_BIT   clock cycles per serial bit (>= 2)
//     FIFO_DEPTH     queued bytes (power of two, >= 2)
//
//   Ports
//     clk        in   1            system clock
//     rst        in   1            synchronous, active-high reset
//     wr_valid   in   1            MMIO store to UART_TX
//     wr_data    in   8            byte to send
//     wr_ready   out  1            queue can accept a byte (= !full)
//     busy       out  1            queue non-empty or frame in flight (registered)
//     full       out  1            queue holds FIFO_DEPTH bytes
//     level      out  clog2(D+1)   bytes queued, excluding the one being shifted
//     uart_tx    out  1            serial line, idle high (registered)
// -----------------------------------------------------------------------------
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_valid,
    input  logic [7:0]                        wr_data,
    output logic                              wr_ready,
    output logic                              busy,
    output logic                              full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
    output logic                              uart_tx
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned LW     = $clog2(FIFO_DEPTH + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

    // ------------------------------------------------------------------
    // Byte queue
    // ------------------------------------------------------------------
    logic          fifo_pop;
    logic [7:0]    fifo_rd_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;
    logic          push_accepted;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_valid),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign wr_ready      = !fifo_full;
    assign push_accepted = wr_valid && !fifo_full;
    assign full          = fifo_full;
    assign level         = fifo_level;

    // ------------------------------------------------------------------
    // Transmit FSM, baud counter, shifter
    // ------------------------------------------------------------------
    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shifter_q, shifter_d;
    logic              busy_q, busy_d;
    logic              uart_tx_q, uart_tx_d;
    logic              bit_done;

    // Last cycle of the current bit period.
    assign bit_done = (baud_q == BAUD_LAST);

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shifter_d = shifter_q;
        fifo_pop  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baud_d    = '0;
                bit_idx_d = '0;
                // Popping straight from IDLE gives the one-cycle gap between
                // queued frames and a one-cycle push-to-start-bit latency.
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shifter_d = fifo_rd_data;
                    state_d   = ST_START;
                end
            end

            ST_START: begin
                if (bit_done) begin
                    baud_d  = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            ST_DATA: begin
                if (bit_done) begin
                    baud_d    = '0;
                    shifter_d = {1'b0, shifter_q[7:1]};
                    // 3-bit index wraps 7 -> 0 as the last data bit completes.
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            ST_STOP: begin
                if (bit_done) begin
                    baud_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // busy is registered: it rises the edge after the first push into an
        // idle transmitter and falls on the edge that ends the last stop bit.
        // A push landing while a frame is still in flight keeps it high, so it
        // never blips low between back-to-back frames.
        busy_d = (state_d != ST_IDLE) || !fifo_empty ||
                 (push_accepted && (state_q != ST_IDLE));

        // The line is registered from the next-state view so it changes on the
        // same edge as the FSM and stays glitch-free at the pin.
        uart_tx_d = line_level(state_d, shifter_d[0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shifter_q <= '0;
            busy_q    <= 1'b0;
            uart_tx_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shifter_q <= shifter_d;
            busy_q    <= busy_d;
            uart_tx_q <= uart_tx_d;
        end
    end

    assign busy    = busy_q;
    assign uart_tx = uart_tx_q;

endmodule : uart_tx_buffered

// File: tb/tb_uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_buffered
//   Directed bench for uart_tx_buffered with CLKS_PER_BIT=4, FIFO_DEPTH=4.
//   Inputs change just after the falling edge; outputs are sampled at the
//   falling edge that follows each rising edge. An independent line decoder
//   reconstructs bytes and their start times from uart_tx.
// -----------------------------------------------------------------------------
module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int LW    = 3;
    localparam int FRAME_GAP = 10 * CPB + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic [7:0]    wr_data;
    logic          wr_ready;
    logic          busy;
    logic          full;
    logic [LW-1:0] level;
    logic          uart_tx;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rst_cnt = 0;

    logic [7:0] rx_q[$];
    int         rx_t[$];

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .busy     (busy),
        .full     (full),
        .level    (level),
        .uart_tx  (uart_tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst === 1'b1) rst_cnt <= rst_cnt + 1;
    end

    // Line decoder: finds a falling edge, samples each bit mid-period and
    // discards any frame during which reset was applied.
    initial begin : decoder
        logic       prev;
        logic [7:0] b;
        int         t0;
        int         r0;
        prev = 1'b1;
        b    = '0;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && uart_tx === 1'b0 && rst !== 1'b1) begin
                t0 = cyc;
                r0 = rst_cnt;
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (CPB) @(negedge clk);
                if (rst_cnt == r0) begin
                    total++;
                    if (uart_tx !== 1'b1) begin
                        bad++;
                        $display("FAIL stop_bit: got %b want 1 (byte %02h)", uart_tx, b);
                    end
                    rx_q.push_back(b);
                    rx_t.push_back(t0);
                end
            end
            prev = uart_tx;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    // One clock: drive inputs, pass the rising edge, stop at the falling edge.
    task automatic tick(input logic v, input logic [7:0] d);
        wr_valid = v;
        wr_data  = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            tick(1'b0, 8'h00);
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle_timeout: busy=%b want 0", name, busy);
        end
        repeat (3) tick(1'b0, 8'h00);
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL rst_uart_tx: got %b want 1", uart_tx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL rst_level: got %0d want 0", level); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL rst_full: got %b want 0", full); end
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL rst_wr_ready: got %b want 1", wr_ready); end
        rst = 1'b0;
        tick(1'b0, 8'h00);
    endtask

    task automatic test_reset_mid_frame();
        int errs;
        tick(1'b1, 8'h3C);
        for (int k = 1; k <= 9; k++) tick(1'b0, 8'h00);
        // Edge N+9 is inside data bit 1 of 0x3C, which is 0.
        total++; if (uart_tx !== 1'b0) begin bad++; $display("FAIL mid_frame_pre: got %b want 0", uart_tx); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL mid_rst_uart_tx: got %b want 1", uart_tx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL mid_rst_level: got %0d want 0", level); end
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst  = 1'b0;
        errs = 0;
        for (int k = 0; k < 45; k++) begin
            tick(1'b0, 8'h00);
            if (uart_tx !== 1'b1 || busy !== 1'b0) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL post_rst_quiet: got %0d active cycles want 0", errs);
        end
    endtask

    task automatic test_single();
        logic [7:0] val;
        logic       exp_tx;
        logic       exp_busy;
        int         base;
        val  = 8'hA5;
        base = rx_q.size();
        tick(1'b1, val);
        total++; if (level !== 3'd1) begin bad++; $display("FAIL single_level_k0: got %0d want 1", level); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_k0: got %b want 0", busy); end
        total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL single_tx_k0: got %b want 1", uart_tx); end
        for (int k = 1; k <= 41; k++) begin
            tick(1'b0, 8'h00);
            if (k <= 4)       exp_tx = 1'b0;
            else if (k <= 36) exp_tx = val[(k - 5) / 4];
            else              exp_tx = 1'b1;
            exp_busy = (k < 41);
            total++;
            if (uart_tx !== exp_tx) begin
                bad++;
                $display("FAIL single_tx_k%0d: got %b want %b", k, uart_tx, exp_tx);
            end
            total++;
            if (busy !== exp_busy) begin
                bad++;
                $display("FAIL single_busy_k%0d: got %b want %b", k, busy, exp_busy);
            end
        end
        total++;
        if (rx_q.size() != base + 1) begin
            bad++;
            $display("FAIL single_rx_count: got %0d want %0d", rx_q.size() - base, 1);
        end else if (rx_q[base] !== val) begin
            bad++;
            $display("FAIL single_rx_byte: got %02h want %02h", rx_q[base], val);
        end
        wait_idle("single");
    endtask

    task automatic test_burst();
        int exp_lvl[5];
        int base;
        int n;
        int drops;
        logic [7:0] exp_b;
        exp_lvl = '{1, 1, 2, 3, 4};
        base = rx_q.size();
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 8'(i * 8'h11));
            total++;
            if (level !== LW'(exp_lvl[i])) begin
                bad++;
                $display("FAIL burst_level_%0d: got %0d want %0d", i, level, exp_lvl[i]);
            end
        end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL burst_full: got %b want 1", full); end
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL burst_wr_ready: got %b want 0", wr_ready); end
        n = 0;
        drops = 0;
        while (rx_q.size() < base + 5 && n < 400) begin
            tick(1'b0, 8'h00);
            if (busy !== 1'b1) drops++;
            n++;
        end
        total++;
        if (drops != 0) begin bad++; $display("FAIL burst_busy_drop: got %0d low cycles want 0", drops); end
        total++;
        if (rx_q.size() != base + 5) begin
            bad++;
            $display("FAIL burst_rx_count: got %0d want 5", rx_q.size() - base);
        end else begin
            for (int i = 0; i < 5; i++) begin
                exp_b = 8'(i * 8'h11);
                total++;
                if (rx_q[base + i] !== exp_b) begin
                    bad++;
                    $display("FAIL burst_rx_byte_%0d: got %02h want %02h", i, rx_q[base + i], exp_b);
                end
                if (i > 0) begin
                    total++;
                    if (rx_t[base + i] - rx_t[base + i - 1] != FRAME_GAP) begin
                        bad++;
                        $display("FAIL burst_spacing_%0d: got %0d want %0d", i,
                                 rx_t[base + i] - rx_t[base + i - 1], FRAME_GAP);
                    end
                end
            end
        end
        wait_idle("burst");
    endtask

    task automatic test_overflow();
        int base;
        int n;
        int held;
        int over;
        logic [7:0] exp_b;
        base = rx_q.size();
        for (int i = 0; i < 5; i++) tick(1'b1, 8'(8'h5A + i));
        n = 0;
        held = 0;
        over = 0;
        while (busy !== 1'b0 && n < 400) begin
            if (full === 1'b1) held++;
            tick(full === 1'b1, 8'hFF);
            if (level > 3'd4) over++;
            n++;
        end
        wr_valid = 1'b0;
        total++;
        if (held == 0) begin bad++; $display("FAIL ovf_never_full: got 0 full cycles want >0"); end
        total++;
        if (over != 0) begin bad++; $display("FAIL ovf_level: got %0d cycles above 4 want 0", over); end
        wait_idle("overflow");
        total++;
        if (rx_q.size() != base + 5) begin
            bad++;
            $display("FAIL ovf_rx_count: got %0d want 5", rx_q.size() - base);
        end else begin
            for (int i = 0; i < 5; i++) begin
                exp_b = 8'(8'h5A + i);
                total++;
                if (rx_q[base + i] !== exp_b) begin
                    bad++;
                    $display("FAIL ovf_rx_byte_%0d: got %02h want %02h", i, rx_q[base + i], exp_b);
                end
            end
        end
    endtask

    task automatic test_simul();
        int base;
        logic [7:0] exp_b;
        base = rx_q.size();
        tick(1'b1, 8'h61);                                 // k=0, popped at k=1
        tick(1'b0, 8'h00);                                 // k=1
        tick(1'b1, 8'h62);                                 // k=2
        tick(1'b1, 8'h63);                                 // k=3
        for (int k = 4; k <= 41; k++) tick(1'b0, 8'h00);
        total++; if (level !== 3'd2) begin bad++; $display("FAIL simul_level_before: got %0d want 2", level); end
        tick(1'b1, 8'h64);                                 // k=42: push and pop together
        total++; if (level !== 3'd2) begin bad++; $display("FAIL simul_level_same: got %0d want 2", level); end
        tick(1'b0, 8'h00);                                 // k=43
        total++; if (level !== 3'd2) begin bad++; $display("FAIL simul_level_after: got %0d want 2", level); end
        wait_idle("simul");
        total++;
        if (rx_q.size() != base + 4) begin
            bad++;
            $display("FAIL simul_rx_count: got %0d want 4", rx_q.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                exp_b = 8'(8'h61 + i);
                total++;
                if (rx_q[base + i] !== exp_b) begin
                    bad++;
                    $display("FAIL simul_rx_byte_%0d: got %02h want %02h", i, rx_q[base + i], exp_b);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int base;
        int n;
        int timeouts;
        logic       exp_busy;
        logic [7:0] exp_b;
        base = rx_q.size();
        timeouts = 0;
        for (int i = 0; i < 16; i++) begin
            n = 0;
            while (busy !== 1'b0 && n < 200) begin
                tick(1'b0, 8'h00);
                n++;
            end
            if (busy !== 1'b0) timeouts++;
            tick(1'b1, 8'(i * 8'h11));
            if (i < 15) begin
                tick(1'b0, 8'h00);
            end else begin
                for (int k = 1; k <= 41; k++) begin
                    tick(1'b0, 8'h00);
                    exp_busy = (k < 41);
                    total++;
                    if (busy !== exp_busy) begin
                        bad++;
                        $display("FAIL wrap_last_busy_k%0d: got %b want %b", k, busy, exp_busy);
                    end
                end
            end
        end
        total++;
        if (timeouts != 0) begin bad++; $display("FAIL wrap_poll_timeout: got %0d want 0", timeouts); end
        wait_idle("wrap");
        total++;
        if (rx_q.size() != base + 16) begin
            bad++;
            $display("FAIL wrap_rx_count: got %0d want 16", rx_q.size() - base);
        end else begin
            for (int i = 0; i < 16; i++) begin
                exp_b = 8'(i * 8'h11);
                total++;
                if (rx_q[base + i] !== exp_b) begin
                    bad++;
                    $display("FAIL wrap_rx_byte_%0d: got %02h want %02h", i, rx_q[base + i], exp_b);
                end
            end
        end
    endtask

    initial begin : main
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        test_reset();
        test_reset_mid_frame();
        test_single();
        test_burst();
        test_overflow();
        test_simul();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_tx_buffered
